// File: rtl/rvx_wait_state_ram.sv
// Slow-memory bus responder: word-organised RAM answering one read/write initiator
// after a programmable number of wait states, optionally stretched by LFSR stalls.
//
// state | meaning
// IDLE  | waiting for a request
// RWAIT | read accepted, counting wait states
// WWAIT | write accepted, counting wait states
// RESP  | single response cycle, then back to IDLE
module rvx_wait_state_ram #(
    parameter int          MEMORY_SIZE  = 8192,
    parameter int          READ_WAIT    = 2,
    parameter int          WRITE_WAIT   = 1,
    parameter bit          RANDOM_STALL = 1'b0,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] address,
    input  logic        rrequest,
    output logic [31:0] rdata,
    output logic        rresponse,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrobe,
    input  logic        wrequest,
    output logic        wresponse,
    output logic        protocol_error
);
    localparam int ADDR_WIDTH = $clog2(MEMORY_SIZE / 4);
    localparam int DEPTH      = MEMORY_SIZE / 4;

    typedef enum logic [1:0] {IDLE, RWAIT, WWAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;
    logic [2:0]            stall_cnt_q, stall_cnt_d;
    logic [15:0]           lfsr_q, lfsr_d;
    logic [ADDR_WIDTH-1:0] index_q, index_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrobe_q, wstrobe_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  rresponse_q, rresponse_d;
    logic                  wresponse_q, wresponse_d;
    logic                  protocol_error_q, protocol_error_d;
    logic                  stall;
    logic                  commit;

    logic [31:0] mem [DEPTH];

    // Only the word index bits select storage; the rest alias.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{address[31:ADDR_WIDTH+2], address[1:0]};

    always_comb begin
        state_d          = state_q;
        wait_cnt_d       = wait_cnt_q;
        stall_cnt_d      = stall_cnt_q;
        index_d          = index_q;
        wdata_d          = wdata_q;
        wstrobe_d        = wstrobe_q;
        rdata_d          = rdata_q;
        rresponse_d      = 1'b0;
        wresponse_d      = 1'b0;
        protocol_error_d = protocol_error_q;
        commit           = 1'b0;
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        stall  = RANDOM_STALL && !lfsr_q[0] && (stall_cnt_q != 3'd7);

        case (state_q)
            IDLE: begin
                if (wrequest) begin
                    index_d     = address[ADDR_WIDTH+1:2];
                    wdata_d     = wdata;
                    wstrobe_d   = wstrobe;
                    wait_cnt_d  = 4'(WRITE_WAIT);
                    stall_cnt_d = 3'd0;
                    state_d     = WWAIT;
                    if (rrequest) protocol_error_d = 1'b1;
                end else if (rrequest) begin
                    index_d     = address[ADDR_WIDTH+1:2];
                    wait_cnt_d  = 4'(READ_WAIT);
                    stall_cnt_d = 3'd0;
                    state_d     = RWAIT;
                end
            end
            RWAIT, WWAIT: begin
                if (rrequest || wrequest) protocol_error_d = 1'b1;
                if (stall) begin
                    stall_cnt_d = stall_cnt_q + 3'd1;
                end else if (wait_cnt_q == 4'd0) begin
                    state_d = RESP;
                    if (state_q == RWAIT) begin
                        rresponse_d = 1'b1;
                        rdata_d     = mem[index_q];
                    end else begin
                        wresponse_d = 1'b1;
                        commit      = 1'b1;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rrequest || wrequest) protocol_error_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            wait_cnt_q       <= 4'd0;
            stall_cnt_q      <= 3'd0;
            lfsr_q           <= LFSR_SEED;
            index_q          <= '0;
            wdata_q          <= 32'h0;
            wstrobe_q        <= 4'h0;
            rdata_q          <= 32'h0;
            rresponse_q      <= 1'b0;
            wresponse_q      <= 1'b0;
            protocol_error_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            wait_cnt_q       <= wait_cnt_d;
            stall_cnt_q      <= stall_cnt_d;
            lfsr_q           <= lfsr_d;
            index_q          <= index_d;
            wdata_q          <= wdata_d;
            wstrobe_q        <= wstrobe_d;
            rdata_q          <= rdata_d;
            rresponse_q      <= rresponse_d;
            wresponse_q      <= wresponse_d;
            protocol_error_q <= protocol_error_d;
        end
    end

    // Storage is not reset; a reset before the commit edge leaves commit low.
    always_ff @(posedge clock) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrobe_q[b]) mem[index_q][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    assign rdata          = rdata_q;
    assign rresponse      = rresponse_q;
    assign wresponse      = wresponse_q;
    assign protocol_error = protocol_error_q;
endmodule
